// File: rtl/tag_compare_nway.sv
// tag_compare_nway: N-way tag compare stage of the DRAM cache controller.
// Captures one request and waits for the WAYS-wide tag/metadata read. It then
// compares all ways in parallel and routes the request to exactly one of four
// channels: read hit, read miss, write hit or write miss.
// Optional feature macro: TAG_CMP_STATS_EN adds four saturating 32-bit
// per-channel handshake counters. When the macro is not defined, cnt_*_o are tied to 0.
module tag_compare_nway #(
  parameter int WAYS   = 4,
  parameter int ADDR_W = 16,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 64,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int REQ_W = 1 + DATA_W + ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [REQ_W-1:0]      req_data_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [WAYS*TAG_W-1:0] rtag_i,
  input  logic [WAYS*2-1:0]     rmeta_i,
  output logic [REQ_W-1:0]      out_data_o,
  output logic [WAY_W-1:0]      out_way_o,
  output logic                  out_dirty_o,
  output logic                  r_hit_valid_o,
  output logic                  r_miss_valid_o,
  output logic                  w_hit_valid_o,
  output logic                  w_miss_valid_o,
  input  logic                  r_hit_ready_i,
  input  logic                  r_miss_ready_i,
  input  logic                  w_hit_ready_i,
  input  logic                  w_miss_ready_i,
  output logic                  multi_hit_o,
  output logic [31:0]           cnt_r_hit_o,
  output logic [31:0]           cnt_r_miss_o,
  output logic [31:0]           cnt_w_hit_o,
  output logic [31:0]           cnt_w_miss_o
);

  typedef enum logic [1:0] {IDLE, WAIT_TAG, OUT} state_t;

  state_t             state_q, state_d;
  logic [REQ_W-1:0]   out_data_q;
  logic [WAY_W-1:0]   out_way_q;
  logic               out_dirty_q;
  logic [3:0]         chan_q;      // {w_miss, w_hit, r_miss, r_hit}
  logic               multi_hit_q;
  logic [WAY_W-1:0]   victim_q;

  logic [3:0]         ch_ready;
  logic               out_fire;
  logic [TAG_W-1:0]   req_tag;
  logic               is_write;

  logic [WAYS-1:0]    hit_vec;
  logic               any_hit, any_inv, multi;
  logic [WAY_W-1:0]   hit_way, inv_way, sel_way;
  logic               hit_dirty, inv_dirty, vic_dirty, sel_dirty;

  assign ch_ready = {w_miss_ready_i, w_hit_ready_i, r_miss_ready_i, r_hit_ready_i};
  // chan_q is non-zero only in OUT, so readies of other channels are masked here
  assign out_fire = |(chan_q & ch_ready);
  assign req_tag  = out_data_q[ADDR_W-1 -: TAG_W];
  assign is_write = out_data_q[REQ_W-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake readies
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rready_o    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = WAIT_TAG;
      end
      WAIT_TAG: begin
        rready_o = 1'b1;
        if (rvalid_i) state_d = OUT;
      end
      OUT: begin
        if (out_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Parallel compare: lowest hit way, lowest invalid way, victim dirty bit
  always_comb begin
    hit_vec   = '0;
    any_hit   = 1'b0;
    any_inv   = 1'b0;
    hit_way   = '0;
    inv_way   = '0;
    hit_dirty = 1'b0;
    inv_dirty = 1'b0;
    vic_dirty = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      hit_vec[i] = rmeta_i[i*2] && (rtag_i[i*TAG_W +: TAG_W] == req_tag);
      if (hit_vec[i] && !any_hit) begin
        any_hit   = 1'b1;
        hit_way   = WAY_W'(i);
        hit_dirty = rmeta_i[i*2+1];
      end
      if (!rmeta_i[i*2] && !any_inv) begin
        any_inv   = 1'b1;
        inv_way   = WAY_W'(i);
        inv_dirty = rmeta_i[i*2+1];
      end
      if (WAY_W'(i) == victim_q) vic_dirty = rmeta_i[i*2+1];
    end
    multi = |(hit_vec & (hit_vec - 1'b1));
    if (any_hit) begin
      sel_way   = hit_way;
      sel_dirty = hit_dirty;
    end else if (any_inv) begin
      sel_way   = inv_way;
      sel_dirty = inv_dirty;
    end else begin
      sel_way   = victim_q;
      sel_dirty = vic_dirty;
    end
  end

  // Request capture, registered compare result, sticky multi-hit, victim pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_way_q   <= '0;
      out_dirty_q <= 1'b0;
      chan_q      <= '0;
      multi_hit_q <= 1'b0;
      victim_q    <= '0;
    end else begin
      if (state_q == IDLE && req_valid_i) out_data_q <= req_data_i;
      if (state_q == WAIT_TAG && rvalid_i) begin
        out_way_q   <= sel_way;
        out_dirty_q <= sel_dirty;
        chan_q      <= 4'b0001 << {is_write, ~any_hit};
        if (multi) multi_hit_q <= 1'b1;
        if (!any_hit && !any_inv)
          victim_q <= (victim_q == WAY_W'(WAYS-1)) ? '0 : victim_q + 1'b1;
      end
      if (state_q == OUT && out_fire) chan_q <= '0;
    end
  end

  assign out_data_o     = out_data_q;
  assign out_way_o      = out_way_q;
  assign out_dirty_o    = out_dirty_q;
  assign r_hit_valid_o  = chan_q[0];
  assign r_miss_valid_o = chan_q[1];
  assign w_hit_valid_o  = chan_q[2];
  assign w_miss_valid_o = chan_q[3];
  assign multi_hit_o    = multi_hit_q;

`ifdef TAG_CMP_STATS_EN
  logic [31:0] cnt_q [4];

  // Saturating per-channel handshake counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 4; k++)
        if (chan_q[k] && ch_ready[k] && cnt_q[k] != '1) cnt_q[k] <= cnt_q[k] + 32'd1;
    end
  end

  assign cnt_r_hit_o  = cnt_q[0];
  assign cnt_r_miss_o = cnt_q[1];
  assign cnt_w_hit_o  = cnt_q[2];
  assign cnt_w_miss_o = cnt_q[3];
`else
  assign cnt_r_hit_o  = '0;
  assign cnt_r_miss_o = '0;
  assign cnt_w_hit_o  = '0;
  assign cnt_w_miss_o = '0;
`endif

endmodule

// File: tb/tb_tag_compare_nway.sv
// Scoreboard bench for tag_compare_nway (WAYS=4, TAG_W=8, ADDR_W=16, DATA_W=64).
module tb_tag_compare_nway;

  localparam int REQ_W = 81;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [REQ_W-1:0] req_data = '0;
  logic rvalid = 1'b0, rready;
  logic [31:0] rtag = '0;
  logic [7:0]  rmeta = '0;
  logic [REQ_W-1:0] out_data;
  logic [1:0]  out_way;
  logic        out_dirty;
  logic        rh_v, rm_v, wh_v, wm_v;
  logic        rh_r = 1'b1, rm_r = 1'b1, wh_r = 1'b1, wm_r = 1'b1;
  logic        multi_hit;
  logic [31:0] c_rh, c_rm, c_wh, c_wm;

  logic [3:0] vld, rdy;
  assign vld = {wm_v, wh_v, rm_v, rh_v};
  assign rdy = {wm_r, wh_r, rm_r, rh_r};

  typedef struct {
    logic [3:0]       chan;
    logic [REQ_W-1:0] data;
    logic [1:0]       way;
    logic             dirty;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  tag_compare_nway #(.WAYS(4), .ADDR_W(16), .TAG_W(8), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .rvalid_i(rvalid), .rready_o(rready), .rtag_i(rtag), .rmeta_i(rmeta),
    .out_data_o(out_data), .out_way_o(out_way), .out_dirty_o(out_dirty),
    .r_hit_valid_o(rh_v), .r_miss_valid_o(rm_v), .w_hit_valid_o(wh_v), .w_miss_valid_o(wm_v),
    .r_hit_ready_i(rh_r), .r_miss_ready_i(rm_r), .w_hit_ready_i(wh_r), .w_miss_ready_i(wm_r),
    .multi_hit_o(multi_hit),
    .cnt_r_hit_o(c_rh), .cnt_r_miss_o(c_rm), .cnt_w_hit_o(c_wh), .cnt_w_miss_o(c_wm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every channel handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && |vld) begin
        chk("onehot", 128'($onehot(vld)), 128'd1);
        if (|(vld & rdy)) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 128'(vld), 128'd0);
          end else begin
            e = exp_q.pop_front();
            chk("chan",  128'(vld),       128'(e.chan));
            chk("data",  128'(out_data),  128'(e.data));
            chk("way",   128'(out_way),   128'(e.way));
            chk("dirty", 128'(out_dirty), 128'(e.dirty));
          end
        end
      end
    end
  end

  // Drive one request and its tag response; checks 1-cycle channel latency
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [63:0] dat,
                        input logic [31:0] tags, input logic [7:0] meta,
                        input logic [3:0] chan, input logic [1:0] way, input logic dirty);
    exp_t e;
    int n;
    e.chan = chan; e.data = {wr, dat, addr}; e.way = way; e.dirty = dirty;
    exp_q.push_back(e);
    req_data  = {wr, dat, addr};
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("req_ready_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rtag  = tags;
    rmeta = meta;
    rvalid = 1'b1;
    chk("rready_wait_tag", 128'(rready), 128'd1);
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("latency_valid", 128'(vld), 128'(chan));
  endtask

  initial begin
    int n;
    #12;
    // Reset state
    chk("rst_req_ready", 128'(req_ready), 128'd1);
    chk("rst_rready",    128'(rready),    128'd0);
    chk("rst_valids",    128'(vld),       128'd0);
    chk("rst_out_data",  128'(out_data),  128'd0);
    chk("rst_multi",     128'(multi_hit), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tag response in IDLE is not accepted
    rvalid = 1'b1;
    chk("idle_rready", 128'(rready), 128'd0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("idle_stays", 128'(req_ready), 128'd1);

    do_req(1'b0, 16'h0A00, 64'hD1, 32'h000A0000, 8'h10, 4'b0001, 2'd2, 1'b0); // read hit way2
    do_req(1'b0, 16'h0B00, 64'hD2, 32'h44332211, 8'h57, 4'b0010, 2'd0, 1'b1); // miss, victim 0
    do_req(1'b0, 16'h0B00, 64'hD3, 32'h44332211, 8'h57, 4'b0010, 2'd1, 1'b0); // miss, victim 1
    do_req(1'b1, 16'h0A00, 64'hD4, 32'h0A332211, 8'h55, 4'b0100, 2'd3, 1'b0); // write hit way3
    do_req(1'b1, 16'h0A00, 64'hD5, 32'h44332211, 8'h51, 4'b1000, 2'd1, 1'b0); // miss into invalid way1
    do_req(1'b0, 16'h0B00, 64'hD6, 32'h44332211, 8'h75, 4'b0010, 2'd2, 1'b1); // victim 2: pointer held

    // Backpressure on r_hit for 5 cycles with a competing request
    rh_r = 1'b0;
    do_req(1'b0, 16'h0C00, 64'hD7, 32'h4433220C, 8'h57, 4'b0001, 2'd0, 1'b1);
    req_data  = {1'b1, 64'hBAD, 16'h0F00};
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid",     128'(vld),       128'd1);
      chk("bp_data",      128'(out_data),  128'({1'b0, 64'hD7, 16'h0C00}));
      chk("bp_way",       128'(out_way),   128'd0);
      chk("bp_dirty",     128'(out_dirty), 128'd1);
      chk("bp_req_ready", 128'(req_ready), 128'd0);
    end
    req_valid = 1'b0;
    rh_r = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 128'(req_ready), 128'd1);

    // Multi-hit: ways 1 and 3 match valid, way2 matches but invalid
    chk("multi_before", 128'(multi_hit), 128'd0);
    do_req(1'b0, 16'h0D00, 64'hD8, 32'h0D0D0D00, 8'h4D, 4'b0001, 2'd1, 1'b1);
    chk("multi_set", 128'(multi_hit), 128'd1);
    do_req(1'b1, 16'h0E00, 64'hD9, 32'h44332211, 8'h55, 4'b1000, 2'd3, 1'b0); // victim 3
    do_req(1'b0, 16'h0B00, 64'hDA, 32'h44332211, 8'h57, 4'b0010, 2'd0, 1'b1); // wraps to 0
    chk("multi_sticky", 128'(multi_hit), 128'd1);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("drain", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;

`ifdef TAG_CMP_STATS_EN
    chk("cnt_r_hit",  128'(c_rh), 128'd3);
    chk("cnt_r_miss", 128'(c_rm), 128'd4);
    chk("cnt_w_hit",  128'(c_wh), 128'd1);
    chk("cnt_w_miss", 128'(c_wm), 128'd2);
`else
    chk("cnt_r_hit",  128'(c_rh), 128'd0);
    chk("cnt_r_miss", 128'(c_rm), 128'd0);
    chk("cnt_w_hit",  128'(c_wh), 128'd0);
    chk("cnt_w_miss", 128'(c_wm), 128'd0);
`endif

    // Reset while in WAIT_TAG
    req_data  = {1'b0, 64'hDB, 16'h0F00};
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_rready", 128'(rready), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valids",   128'(vld),       128'd0);
    chk("mid_rst_req_rdy",  128'(req_ready), 128'd1);
    chk("mid_rst_out_data", 128'(out_data),  128'd0);
    chk("mid_rst_multi",    128'(multi_hit), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_rdy", 128'(req_ready), 128'd1);
    chk("post_rst_valids",  128'(vld),       128'd0);
    chk("post_rst_cnt",     128'(c_rh | c_rm | c_wh | c_wm), 128'd0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
